// File: rtl/mesh_term_sink.sv
// Terminal receive stage for one mesh port: drains the mesh FIFO with a pop pulse,
// filters packets by destination, buffers them in a local FWFT FIFO and counts traffic.
module mesh_term_sink #(
  parameter int unsigned pckg_sz    = 16,
  parameter int unsigned fifo_depth = 8,
  parameter logic [7:0]  bdcst      = 8'hFF,
  parameter logic [3:0]  ROW_ID     = 4'd0,
  parameter logic [3:0]  COL_ID     = 4'd0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pndng,
  input  logic [pckg_sz-1:0] data_out,
  output logic               pop,
  output logic [pckg_sz-1:0] o_data,
  output logic               o_valid,
  input  logic               o_ready,
  output logic [CNT_W-1:0]   rx_cnt,
  output logic [CNT_W-1:0]   bcst_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic               err,
  input  logic               clr_cnt
);

  localparam int unsigned AW = $clog2(fifo_depth);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POP  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_pop;
  logic               w_pop_nxt;

  logic [pckg_sz-1:0] r_mem [fifo_depth];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;

  logic [CNT_W-1:0]   r_rx_cnt;
  logic [CNT_W-1:0]   r_bcst_cnt;
  logic [CNT_W-1:0]   r_err_cnt;
  logic               r_err;

  logic [7:0]         w_dest;
  logic               w_is_bcst;
  logic               w_is_match;
  logic               w_in_pop;
  logic               w_wr;
  logic               w_rd;
  logic               w_full;
  logic               w_ev_rx;
  logic               w_ev_bcst;
  logic               w_ev_err;

  // Destination classification of the mesh FIFO head; broadcast takes priority
  assign w_dest     = data_out[pckg_sz-1 -: 8];
  assign w_is_bcst  = (w_dest == bdcst);
  assign w_is_match = !w_is_bcst && (w_dest[7:4] == ROW_ID) && (w_dest[3:0] == COL_ID);

  assign w_in_pop  = (r_state == S_POP);
  assign w_ev_rx   = w_in_pop && w_is_match;
  assign w_ev_bcst = w_in_pop && w_is_bcst;
  assign w_ev_err  = w_in_pop && !w_is_bcst && !w_is_match;
  assign w_wr      = w_ev_rx || w_ev_bcst;
  assign w_full    = (r_count == CW'(fifo_depth));
  assign w_rd      = o_valid && o_ready;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_pop   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pop   <= w_pop_nxt;
    end
  end

  // Next state; pop is asserted for the cycle spent in POP only
  always_comb begin
    w_state_nxt = r_state;
    w_pop_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (pndng && !w_full) begin
          w_state_nxt = S_POP;
          w_pop_nxt   = 1'b1;
        end
      end
      S_POP:   w_state_nxt = S_GAP;
      S_GAP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Local FWFT buffer; full is only tested in IDLE so a single write is ever in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(fifo_depth); i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= data_out;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Saturating counters; a coincident clear restarts the count from the current event
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_cnt   <= '0;
      r_bcst_cnt <= '0;
      r_err_cnt  <= '0;
      r_err      <= 1'b0;
    end else if (clr_cnt) begin
      r_rx_cnt   <= w_ev_rx   ? CNT_W'(1) : '0;
      r_bcst_cnt <= w_ev_bcst ? CNT_W'(1) : '0;
      r_err_cnt  <= w_ev_err  ? CNT_W'(1) : '0;
      r_err      <= w_ev_err;
    end else begin
      if (w_ev_rx && (r_rx_cnt != '1)) begin
        r_rx_cnt <= r_rx_cnt + CNT_W'(1);
      end
      if (w_ev_bcst && (r_bcst_cnt != '1)) begin
        r_bcst_cnt <= r_bcst_cnt + CNT_W'(1);
      end
      if (w_ev_err && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
      if (w_ev_err) begin
        r_err <= 1'b1;
      end
    end
  end

  assign pop      = r_pop;
  assign o_data   = r_mem[r_rd_ptr];
  assign o_valid  = (r_count != '0);
  assign rx_cnt   = r_rx_cnt;
  assign bcst_cnt = r_bcst_cnt;
  assign err_cnt  = r_err_cnt;
  assign err      = r_err;

endmodule

// File: tb/tb_mesh_term_sink.sv
// Directed bench for mesh_term_sink: a queue-based mesh FIFO model on the input side,
// an ordered scoreboard on the output side, and a 2-bit-counter twin for saturation.
module tb_mesh_term_sink;

  logic        clk = 1'b0;
  logic        reset;
  logic        pndng;
  logic [15:0] data_out;
  logic        o_ready;
  logic        clr_cnt;

  logic        pop, o_valid, err;
  logic [15:0] o_data;
  logic [15:0] rx_cnt, bcst_cnt, err_cnt;

  logic        pop_b, o_valid_b, err_b;
  logic [15:0] o_data_b;
  logic [1:0]  rx_b, bcst_b, err_cnt_b;

  int checks = 0;
  int errors = 0;
  int pop_count = 0;
  logic last_pop = 1'b0;

  logic [15:0] mq[$];
  logic [15:0] exp_q[$];

  typedef struct {
    logic [15:0] pkt;
    int          cls;   // 0 match, 1 broadcast, 2 misroute
  } vec_t;

  vec_t vecs[10];
  int m_rx, m_bc, m_er;
  logic m_err;

  mesh_term_sink #(.pckg_sz(16), .fifo_depth(8), .bdcst(8'hFF), .ROW_ID(4'd1), .COL_ID(4'd2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .data_out(data_out), .pop(pop),
    .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready),
    .rx_cnt(rx_cnt), .bcst_cnt(bcst_cnt), .err_cnt(err_cnt), .err(err), .clr_cnt(clr_cnt)
  );

  mesh_term_sink #(.pckg_sz(16), .fifo_depth(8), .bdcst(8'hFF), .ROW_ID(4'd1), .COL_ID(4'd2), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .pndng(pndng), .data_out(data_out), .pop(pop_b),
    .o_data(o_data_b), .o_valid(o_valid_b), .o_ready(o_ready),
    .rx_cnt(rx_b), .bcst_cnt(bcst_b), .err_cnt(err_cnt_b), .err(err_b), .clr_cnt(clr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void mesh_upd();
    pndng    = (mq.size() != 0);
    data_out = (mq.size() != 0) ? mq[0] : 16'h0000;
  endfunction

  function automatic void mesh_push(input logic [15:0] w);
    mq.push_back(w);
    mesh_upd();
  endfunction

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  // Mesh FIFO model: a pop seen in a cycle removes the head at the end of that cycle
  always @(negedge clk) begin
    if (pop) begin
      pop_count++;
      chk("pop_single_cycle", {31'd0, last_pop}, 32'd0);
      last_pop = 1'b1;
      @(posedge clk);
      #1;
      if (reset && mq.size() != 0) begin
        void'(mq.pop_front());
        mesh_upd();
      end
    end else begin
      last_pop = 1'b0;
    end
  end

  // Consumer-side scoreboard: every handshake must deliver the next expected word
  always @(negedge clk) begin
    if (reset && o_valid && o_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_delivery", 32'(o_data), 32'hFFFF_FFFF);
      end else begin
        chk("deliver", 32'(o_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic wait_drain(input string name, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (mq.size() == 0 && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk({name, "_timeout"}, 32'd1, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_pop(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pop) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk({name, "_pop_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic chk_cnts(input string name);
    chk({name, "_rx"},    32'(rx_cnt),    32'(m_rx));
    chk({name, "_bcst"},  32'(bcst_cnt),  32'(m_bc));
    chk({name, "_errc"},  32'(err_cnt),   32'(m_er));
    chk({name, "_err"},   32'(err),       32'(m_err));
    chk({name, "_rx_b"},  32'(rx_b),      32'(sat3(m_rx)));
    chk({name, "_bc_b"},  32'(bcst_b),    32'(sat3(m_bc)));
    chk({name, "_errc_b"},32'(err_cnt_b), 32'(sat3(m_er)));
    chk({name, "_err_b"}, 32'(err_b),     32'(m_err));
  endtask

  initial begin
    vecs[0] = '{16'hFF05, 1};
    vecs[1] = '{16'h3400, 2};
    vecs[2] = '{16'h1200, 0};
    vecs[3] = '{16'h1100, 2};
    vecs[4] = '{16'h2200, 2};
    vecs[5] = '{16'h12FF, 0};
    vecs[6] = '{16'hFF00, 1};
    vecs[7] = '{16'h0000, 2};
    vecs[8] = '{16'hF200, 2};
    vecs[9] = '{16'h1F00, 2};

    reset = 1'b0; o_ready = 1'b0; clr_cnt = 1'b0;
    mesh_upd();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_pop", 32'(pop), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_pop_b", 32'(pop_b), 32'd0);
    chk("rst_valid_b", 32'(o_valid_b), 32'd0);
    chk("rst_data_b", 32'(o_data_b), 32'd0);
    m_rx = 0; m_bc = 0; m_er = 0; m_err = 1'b0;
    chk_cnts("rst");

    // Single match: latency and one-cycle pop/valid
    @(posedge clk); #1;
    o_ready = 1'b1;
    mesh_push(16'h12AB);
    exp_q.push_back(16'h12AB);
    @(negedge clk); chk("lat_pop_pre", 32'(pop), 32'd0);
    @(negedge clk); chk("lat_pop", 32'(pop), 32'd1);
    @(negedge clk);
    chk("lat_pop_off", 32'(pop), 32'd0);
    chk("lat_valid", 32'(o_valid), 32'd1);
    chk("lat_data", 32'(o_data), 32'h12AB);
    @(negedge clk); chk("lat_valid_off", 32'(o_valid), 32'd0);
    m_rx = 1;
    chk_cnts("single");
    wait_drain("single", 20);

    // Classification table
    for (int v = 0; v < 10; v++) begin
      @(posedge clk); #1;
      mesh_push(vecs[v].pkt);
      if (vecs[v].cls != 2) exp_q.push_back(vecs[v].pkt);
      case (vecs[v].cls)
        0: m_rx++;
        1: m_bc++;
        default: begin m_er++; m_err = 1'b1; end
      endcase
      wait_drain("vec", 40);
      chk_cnts($sformatf("vec%0d", v));
    end

    // Back-pressure: 8 pops fill the buffer, the rest wait in the mesh
    @(posedge clk); #1;
    o_ready = 1'b0;
    pop_count = 0;
    for (int i = 0; i < 10; i++) begin
      mesh_push(16'h1200 + 16'(i));
      exp_q.push_back(16'h1200 + 16'(i));
    end
    repeat (60) @(negedge clk);
    chk("bp_pops", 32'(pop_count), 32'd8);
    chk("bp_valid", 32'(o_valid), 32'd1);
    chk("bp_head", 32'(o_data), 32'h1200);
    chk("bp_mesh_left", 32'(mq.size()), 32'd2);
    @(posedge clk); #1;
    o_ready = 1'b1;
    wait_drain("bp", 200);
    chk("bp_all_delivered", 32'(exp_q.size()), 32'd0);
    chk("bp_total_pops", 32'(pop_count), 32'd10);
    m_rx += 10;
    chk_cnts("bp");

    // Clear coincident with a match write restarts at 1
    @(posedge clk); #1;
    mesh_push(16'h12CD);
    exp_q.push_back(16'h12CD);
    wait_pop("clr_match");
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    m_rx = 1; m_bc = 0; m_er = 0; m_err = 1'b0;
    chk_cnts("clr_match");
    wait_drain("clr_match", 20);

    // Clear coincident with a misroute leaves err set
    @(posedge clk); #1;
    mesh_push(16'h3400);
    wait_pop("clr_mis");
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    m_rx = 0; m_er = 1; m_err = 1'b1;
    chk_cnts("clr_mis");
    wait_drain("clr_mis", 20);

    // Reset during POP with three words buffered
    @(posedge clk); #1;
    o_ready = 1'b0;
    for (int i = 1; i <= 3; i++) mesh_push(16'h1200 + 16'(i));
    wait_drain("rst_fill", 40);
    chk("rst_fill_valid", 32'(o_valid), 32'd1);
    mesh_push(16'h1204);
    wait_pop("rst_mid");
    reset = 1'b0;
    #1;
    chk("rstmid_pop", 32'(pop), 32'd0);
    chk("rstmid_valid", 32'(o_valid), 32'd0);
    chk("rstmid_data", 32'(o_data), 32'd0);
    m_rx = 0; m_bc = 0; m_er = 0; m_err = 1'b0;
    chk_cnts("rstmid");
    mq.delete();
    exp_q.delete();
    mesh_upd();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_pop", 32'(pop), 32'd0);
    chk("post_rst_valid", 32'(o_valid), 32'd0);
    chk_cnts("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
